// File: rtl/fifo_pkg.sv
// Purpose : shared types and helpers for the programmable synchronous FIFO family.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: fifo_mode_e selects the read mode; cnt_width() sizes count/threshold
//           buses so they can hold every occupancy 0..DEPTH.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,  // registered read, data_out updates the cycle after a pop
    FIFO_FWFT = 1'b1   // head word presented combinationally, rd_en pops it
  } fifo_mode_e;

  // Width needed to represent 0..depth inclusive (a full FIFO must be encodable).
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Purpose : DEPTH x WIDTH register array backing the FIFO storage.
// Latency : write lands on the rising edge; read is combinational from raddr.
// Backpr. : none; the caller decides when we is asserted.
// Ports   : clk; we/waddr/wdata synchronous write port; raddr/rdata async read port.
//           Contents are deliberately not reset.
module fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Pointers are kept below DEPTH by the owner, so no range guard is needed.
  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Purpose : single-clock FIFO, any depth >= 2, programmable almost-full/almost-empty,
//           standard (registered) or first-word-fall-through read mode.
// Latency : write visible in count/flags 1 cycle later; read data 1 cycle (std) / 0 (FWFT).
// Backpr. : writes at full are rejected (overflow) unless a read is accepted the same
//           cycle; reads at empty are rejected (underflow). Ack/overflow/underflow lag 1 cycle.
// Ports   : clk, rst (sync, active-high); wr_en/data_in write side; rd_en/data_out read
//           side; afull_thresh/aempty_thresh run-time thresholds; full, empty, almostfull,
//           almostempty combinational flags; wr_ack, overflow, underflow registered pulses;
//           count = occupancy 0..FIFO_DEPTH.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter  int FIFO_WIDTH = 16,
  parameter  int FIFO_DEPTH = 8,
  parameter  int FWFT       = 0,
  localparam int CNT_W      = fifo_pkg::cnt_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic [CNT_W-1:0]      afull_thresh,
  input  logic [CNT_W-1:0]      aempty_thresh,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic [CNT_W-1:0]      count
);

  localparam int         PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam fifo_mode_e MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

  // Explicit wrap so non power-of-two depths never index past the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  mem_we;
  logic [FIFO_WIDTH-1:0] mem_rdata;

  // ---------------------------------------------------------------------------
  // Flags: purely combinational from occupancy, so a threshold change is seen
  // in the same cycle it is applied.
  // ---------------------------------------------------------------------------
  assign count       = count_q;
  assign full        = (count_q == DEPTH_CNT);
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= afull_thresh);
  assign almostempty = !empty && (count_q <= aempty_thresh);

  // A read frees a slot in the same cycle, which is what lets a write at full
  // pass through. A read at empty is never accepted, even alongside a write.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  // Requests are ignored while reset is held, including the storage write.
  assign mem_we = wr_acc && !rst;

  // ---------------------------------------------------------------------------
  // Pointers, occupancy and the handshake pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rd_acc) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      // Simultaneous accept leaves occupancy unchanged.
      unique case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      wr_ack    <= wr_acc;
      overflow  <= wr_en && !wr_acc;
      underflow <= rd_en && !rd_acc;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  fifo_mem #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  // ---------------------------------------------------------------------------
  // Read port: FWFT exposes the head entry directly; standard mode captures the
  // head into an output register on each accepted read and holds otherwise.
  // ---------------------------------------------------------------------------
  if (MODE == FIFO_FWFT) begin : g_fwft
    // Undefined while empty, but stable because rd_ptr only moves on a pop.
    assign data_out = mem_rdata;
  end else begin : g_std
    logic [FIFO_WIDTH-1:0] dout_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q <= '0;
      end else if (rd_acc) begin
        dout_q <= mem_rdata;
      end
    end

    assign data_out = dout_q;
  end

endmodule
